gf_serial_io_ctrl: RTL and testbench

//   Framed serial I/O controller between a low-pin-count bench/pad interface and a GF

---
 rtl/gf_serial_io_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_gf_serial_io_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gf_serial_io_ctrl.sv
// Framed serial I/O controller between a serial pad interface and a GF core.
// Optional WAIT watchdog is compiled in with `define GF_IO_TIMEOUT_EN.
module gf_serial_io_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int LANES      = 1,
    parameter int TIMEOUT    = 255
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      load_en,
    input  logic [LANES-1:0]          sin_a,
    input  logic [LANES-1:0]          sin_b,
    input  logic                      start,
    output logic [DATA_WIDTH-1:0]     core_a,
    output logic [DATA_WIDTH-1:0]     core_b,
    output logic                      core_start,
    input  logic                      core_done,
    input  logic [2*DATA_WIDTH-1:0]   core_mult,
    input  logic [DATA_WIDTH-1:0]     core_res,
    output logic [LANES-1:0]          sout_mult,
    output logic [LANES-1:0]          sout_res,
    output logic                      sout_valid,
    output logic                      busy,
    output logic                      done,
    output logic                      frame_err,
    output logic                      timeout
);

    localparam int W     = DATA_WIDTH;
    localparam int BEATS = W / LANES;
    localparam int CW    = $clog2(2 * BEATS) + 1;

    localparam logic [CW-1:0] LAST_LD = CW'(BEATS - 1);
    localparam logic [CW-1:0] LAST_UL = CW'(2 * BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ARMED,
        S_WAIT,
        S_UNLOAD
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [2*W-1:0]   mult_q, mult_d;
    logic [W-1:0]     res_q, res_d;
    logic             ferr_q, ferr_d;
    logic             cstart;
    logic [W-1:0]     a_shift;
    logic [W-1:0]     b_shift;

`ifdef GF_IO_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    logic [WDW-1:0]   wd_q, wd_d;
    logic             tmo_q, tmo_d;
`endif

    assign a_shift = {a_q[W-LANES-1:0], sin_a};
    assign b_shift = {b_q[W-LANES-1:0], sin_b};

    // State, counters and data registers; reset discards any frame in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            mult_q  <= '0;
            res_q   <= '0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mult_q  <= mult_d;
            res_q   <= res_d;
            ferr_q  <= ferr_d;
        end
    end

`ifdef GF_IO_TIMEOUT_EN
    // Watchdog counter and sticky timeout flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wd_q  <= '0;
            tmo_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            tmo_q <= tmo_d;
        end
    end
`endif

    // Next-state logic: framing, launch handshake, capture and unload.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        mult_d  = mult_q;
        res_d   = res_q;
        ferr_d  = ferr_q;
        cstart  = 1'b0;
`ifdef GF_IO_TIMEOUT_EN
        wd_d    = wd_q;
        tmo_d   = tmo_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (load_en) begin
                    a_d     = a_shift;
                    b_d     = b_shift;
                    cnt_d   = CW'(1);
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (load_en) begin
                    a_d = a_shift;
                    b_d = b_shift;
                    if (cnt_q == LAST_LD) begin
                        cnt_d   = '0;
                        ferr_d  = 1'b0;
                        state_d = S_ARMED;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    ferr_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            S_ARMED: begin
                // A new frame takes priority over a launch request.
                if (load_en) begin
                    a_d     = a_shift;
                    b_d     = b_shift;
                    cnt_d   = CW'(1);
                    state_d = S_LOAD;
                end else if (start) begin
                    cstart  = 1'b1;
                    state_d = S_WAIT;
`ifdef GF_IO_TIMEOUT_EN
                    wd_d    = '0;
                    tmo_d   = 1'b0;
`endif
                end
            end
            S_WAIT: begin
                if (core_done) begin
                    mult_d  = core_mult;
                    res_d   = core_res;
                    cnt_d   = '0;
                    state_d = S_UNLOAD;
                end else begin
`ifdef GF_IO_TIMEOUT_EN
                    if (wd_q == WD_LAST) begin
                        tmo_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        wd_d = wd_q + WDW'(1);
                    end
`endif
                end
            end
            S_UNLOAD: begin
                mult_d = mult_q << LANES;
                res_d  = res_q << LANES;
                if (cnt_q == LAST_UL) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode; serial outputs are gated to UNLOAD beats only.
    always_comb begin
        core_a     = a_q;
        core_b     = b_q;
        core_start = cstart;
        sout_valid = (state_q == S_UNLOAD);
        sout_mult  = '0;
        sout_res   = '0;
        if (state_q == S_UNLOAD) begin
            sout_mult = mult_q[2*W-1 -: LANES];
            sout_res  = res_q[W-1 -: LANES];
        end
        busy       = (state_q == S_LOAD) ||
                     (state_q == S_WAIT) ||
                     (state_q == S_UNLOAD);
        done       = (state_q == S_UNLOAD) && (cnt_q == LAST_UL);
        frame_err  = ferr_q;
`ifdef GF_IO_TIMEOUT_EN
        timeout    = tmo_q;
`else
        timeout    = 1'b0;
`endif
    end

endmodule

// File: tb/tb_gf_serial_io_ctrl.sv
// Directed bench for gf_serial_io_ctrl at W=8, LANES=2 (4 beats per word).
// Define GF_IO_TIMEOUT_EN to exercise the watchdog build.
module tb_gf_serial_io_ctrl;

    logic        clk;
    logic        resetn;
    logic        load_en;
    logic [1:0]  sin_a;
    logic [1:0]  sin_b;
    logic        start;
    logic [7:0]  core_a;
    logic [7:0]  core_b;
    logic        core_start;
    logic        core_done;
    logic [15:0] core_mult;
    logic [7:0]  core_res;
    logic [1:0]  sout_mult;
    logic [1:0]  sout_res;
    logic        sout_valid;
    logic        busy;
    logic        done;
    logic        frame_err;
    logic        timeout;

    int nvec;
    int nbad;

    gf_serial_io_ctrl #(
        .DATA_WIDTH (8),
        .LANES      (2),
        .TIMEOUT    (16)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .load_en    (load_en),
        .sin_a      (sin_a),
        .sin_b      (sin_b),
        .start      (start),
        .core_a     (core_a),
        .core_b     (core_b),
        .core_start (core_start),
        .core_done  (core_done),
        .core_mult  (core_mult),
        .core_res   (core_res),
        .sout_mult  (sout_mult),
        .sout_res   (sout_res),
        .sout_valid (sout_valid),
        .busy       (busy),
        .done       (done),
        .frame_err  (frame_err),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        le;
        logic [1:0]  sa;
        logic [1:0]  sb;
        logic        st;
        logic        cd;
        logic [15:0] cm;
        logic [7:0]  cr;
        logic        busy;
        logic        cs;
        logic        sv;
        logic        dn;
        logic [1:0]  sm;
        logic [1:0]  sr;
        logic [7:0]  ca;
        logic [7:0]  cb;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(
        input logic le, input logic [1:0] sa, input logic [1:0] sb,
        input logic st, input logic cd,
        input logic [15:0] cm, input logic [7:0] cr,
        input logic eb, input logic ecs, input logic esv, input logic edn,
        input logic [1:0] esm, input logic [1:0] esr,
        input logic [7:0] eca, input logic [7:0] ecb);
        vec_t v;
        v.le = le; v.sa = sa; v.sb = sb; v.st = st; v.cd = cd;
        v.cm = cm; v.cr = cr;
        v.busy = eb; v.cs = ecs; v.sv = esv; v.dn = edn;
        v.sm = esm; v.sr = esr; v.ca = eca; v.cb = ecb;
        return v;
    endfunction

    task automatic chk(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic le, input logic [1:0] sa,
                        input logic [1:0] sb, input logic st,
                        input logic cd, input logic [15:0] cm,
                        input logic [7:0] cr);
        @(negedge clk);
        load_en   = le;
        sin_a     = sa;
        sin_b     = sb;
        start     = st;
        core_done = cd;
        core_mult = cm;
        core_res  = cr;
        #1;
    endtask

    task automatic idle();
        step(1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 16'h0, 8'h0);
    endtask

    task automatic load_frame(input logic [7:0] a, input logic [7:0] b);
        for (int i = 0; i < 4; i++)
            step(1'b1, a[7-2*i -: 2], b[7-2*i -: 2],
                 1'b0, 1'b0, 16'h0, 8'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn    = 1'b0;
        load_en   = 1'b0;
        sin_a     = '0;
        sin_b     = '0;
        start     = 1'b0;
        core_done = 1'b0;
        core_mult = '0;
        core_res  = '0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    logic [23:0] got;
    logic [23:0] want;
    int          ndone;
    int          nidle;
    int          wcnt;

    initial begin
        nvec = 0;
        nbad = 0;
        resetn    = 1'b0;
        load_en   = 1'b0;
        sin_a     = '0;
        sin_b     = '0;
        start     = 1'b0;
        core_done = 1'b0;
        core_mult = '0;
        core_res  = '0;

        // Load B4/3C, launch, core answers on 3rd WAIT cycle, unload.
        tbl[0]  = mk(1,2,0,0,0,16'h0,8'h0,   0,0,0,0,0,0,8'h00,8'h00);
        tbl[1]  = mk(1,3,3,0,0,16'h0,8'h0,   1,0,0,0,0,0,8'h02,8'h00);
        tbl[2]  = mk(1,1,3,0,0,16'h0,8'h0,   1,0,0,0,0,0,8'h0B,8'h03);
        tbl[3]  = mk(1,0,0,0,0,16'h0,8'h0,   1,0,0,0,0,0,8'h2D,8'h0F);
        tbl[4]  = mk(0,0,0,0,0,16'h0,8'h0,   0,0,0,0,0,0,8'hB4,8'h3C);
        tbl[5]  = mk(0,0,0,1,0,16'h0,8'h0,   0,1,0,0,0,0,8'hB4,8'h3C);
        tbl[6]  = mk(0,0,0,0,0,16'h0,8'h0,   1,0,0,0,0,0,8'hB4,8'h3C);
        tbl[7]  = mk(0,0,0,0,0,16'h0,8'h0,   1,0,0,0,0,0,8'hB4,8'h3C);
        tbl[8]  = mk(0,0,0,0,1,16'h1234,8'h5A, 1,0,0,0,0,0,8'hB4,8'h3C);
        tbl[9]  = mk(0,0,0,0,0,16'h0,8'h0,   1,0,1,0,0,1,8'hB4,8'h3C);
        tbl[10] = mk(0,0,0,0,0,16'h0,8'h0,   1,0,1,0,1,1,8'hB4,8'h3C);
        tbl[11] = mk(1,3,3,1,1,16'hFFFF,8'hFF, 1,0,1,0,0,2,8'hB4,8'h3C);
        tbl[12] = mk(0,0,0,0,0,16'h0,8'h0,   1,0,1,0,2,2,8'hB4,8'h3C);
        tbl[13] = mk(0,0,0,0,0,16'h0,8'h0,   1,0,1,0,0,0,8'hB4,8'h3C);
        tbl[14] = mk(0,0,0,0,0,16'h0,8'h0,   1,0,1,0,3,0,8'hB4,8'h3C);
        tbl[15] = mk(0,0,0,0,0,16'h0,8'h0,   1,0,1,0,1,0,8'hB4,8'h3C);
        tbl[16] = mk(0,0,0,0,0,16'h0,8'h0,   1,0,1,1,0,0,8'hB4,8'h3C);
        tbl[17] = mk(0,0,0,0,0,16'h0,8'h0,   0,0,0,0,0,0,8'hB4,8'h3C);

        #1;
        chk("reset_outputs",
            {32'h0, core_a, core_b, core_start, sout_mult, sout_res,
             sout_valid, busy, done, frame_err, timeout}, 64'h0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 18; i++) begin
            step(tbl[i].le, tbl[i].sa, tbl[i].sb, tbl[i].st,
                 tbl[i].cd, tbl[i].cm, tbl[i].cr);
            got  = {busy, core_start, sout_valid, done,
                    sout_mult, sout_res, core_a, core_b};
            want = {tbl[i].busy, tbl[i].cs, tbl[i].sv, tbl[i].dn,
                    tbl[i].sm, tbl[i].sr, tbl[i].ca, tbl[i].cb};
            chk($sformatf("vec%0d", i), {40'h0, got}, {40'h0, want});
        end

        // Aborted frame sets frame_err; next full frame clears it.
        step(1'b1, 2'd1, 2'd1, 1'b0, 1'b0, 16'h0, 8'h0);
        step(1'b1, 2'd1, 2'd1, 1'b0, 1'b0, 16'h0, 8'h0);
        step(1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 16'h0, 8'h0);
        chk("abort_busy", {63'h0, busy}, 64'h1);
        idle();
        chk("abort_err", {62'h0, busy, frame_err}, 64'h1);
        load_frame(8'h96, 8'h69);
        idle();
        chk("reload_clr",
            {46'h0, busy, frame_err, core_a, core_b}, {48'h0, 16'h9669});

        // start together with load_en in ARMED: reload wins.
        step(1'b1, 2'd1, 2'd1, 1'b1, 1'b0, 16'h0, 8'h0);
        chk("simul_nostart", {63'h0, core_start}, 64'h0);
        step(1'b1, 2'd2, 2'd1, 1'b0, 1'b0, 16'h0, 8'h0);
        chk("simul_busy", {63'h0, busy}, 64'h1);
        step(1'b1, 2'd3, 2'd1, 1'b0, 1'b0, 16'h0, 8'h0);
        step(1'b1, 2'd0, 2'd1, 1'b0, 1'b0, 16'h0, 8'h0);
        idle();
        chk("simul_words",
            {47'h0, busy, core_a, core_b}, {48'h0, 16'h6C55});

        // start in IDLE is ignored.
        do_reset();
        step(1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 16'h0, 8'h0);
        chk("idle_start", {62'h0, core_start, busy}, 64'h0);
        idle();
        chk("idle_after", {62'h0, core_start, busy}, 64'h0);

        // Asynchronous reset during UNLOAD clears every output at once.
        load_frame(8'hB4, 8'h3C);
        step(1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 16'h0, 8'h0);
        step(1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 16'hABCD, 8'hEF);
        idle();
        idle();
        idle();
        chk("unload_active", {63'h0, sout_valid}, 64'h1);
        resetn = 1'b0;
        #1;
        chk("reset_mid_unload",
            {32'h0, core_a, core_b, core_start, sout_mult, sout_res,
             sout_valid, busy, done, frame_err, timeout}, 64'h0);
        @(negedge clk);
        resetn = 1'b1;
        ndone = 0;
        nidle = 0;
        for (int i = 0; i < 10; i++) begin
            idle();
            if (done) ndone++;
            if (!busy && !sout_valid && sout_mult == 0 && sout_res == 0)
                nidle++;
        end
        chk("post_reset_quiet", {32'(ndone), 32'(nidle)},
            {32'd0, 32'd10});

        // Core never answers.
        load_frame(8'h11, 8'h22);
        step(1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 16'h0, 8'h0);
        chk("wd_launch", {63'h0, core_start}, 64'h1);
        ndone = 0;
        wcnt  = 0;
`ifdef GF_IO_TIMEOUT_EN
        for (int i = 0; i < 16; i++) begin
            idle();
            if (busy && !timeout) wcnt++;
            if (done) ndone++;
        end
        chk("wd_wait16", {32'(wcnt), 32'(ndone)}, {32'd16, 32'd0});
        idle();
        chk("wd_expire", {61'h0, busy, timeout, done}, 64'h2);
        load_frame(8'h11, 8'h22);
        step(1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 16'h0, 8'h0);
        idle();
        chk("wd_clear", {62'h0, busy, timeout}, 64'h2);
        do_reset();
`else
        for (int i = 0; i < 1000; i++) begin
            idle();
            if (busy && !sout_valid) wcnt++;
            if (done) ndone++;
        end
        chk("wait_hold", {32'(wcnt), 32'(ndone)}, {32'd1000, 32'd0});
        chk("no_timeout", {63'h0, timeout}, 64'h0);
        step(1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 16'hC000, 8'h80);
        idle();
        chk("late_beat1", {60'h0, sout_mult, sout_res}, {60'h0, 4'b1110});
        ndone = 0;
        for (int i = 0; i < 7; i++) begin
            idle();
            if (done) ndone = i + 2;
        end
        chk("late_done_beat", 64'(ndone), 64'd8);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
